// File: rtl/sdram_port_arb.sv
// Burst scheduler sharing one SDRAM controller between a write FIFO and a read FIFO.
// Issues fixed-length level requests, counts acks and keeps per-channel frame addresses.
module sdram_port_arb #(
   parameter logic [8:0]        BURST_LEN   = 9'd256,
   parameter int                ADDR_W      = 22,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(307200),
   parameter logic [9:0]        RD_THRESH   = 10'd512
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sdram_init_done,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [9:0]        wr_fifo_lvl,
   input  logic [9:0]        rd_fifo_lvl,
   input  logic              frame_sync,
   output logic              sdram_wr_req,
   output logic              sdram_rd_req,
   input  logic              sdram_wr_ack,
   input  logic              sdram_rd_ack,
   output logic [9:0]        sdwr_byte,
   output logic [9:0]        sdrd_byte,
   output logic [ADDR_W-1:0] sys_addr,
   output logic              wr_frame_done,
   output logic              rd_frame_done,
   output logic              busy,
   output logic              last_grant
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER} state_t;

   localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] FRAME_END = BASE_ADDR + FRAME_WORDS;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [ADDR_W-1:0] wr_sum, rd_sum;
   logic [8:0]        ack_cnt;
   logic              any_grant;
   logic              rd_pend;
   logic              wr_elig, rd_elig;
   logic              grant_wr, grant_rd;
   logic              ack_first, ack_next;
   logic              wr_last, rd_last;
   logic              rd_active;

   assign sdwr_byte    = {1'b0, BURST_LEN};
   assign sdrd_byte    = {1'b0, BURST_LEN};
   assign sdram_wr_req = (state == WR_REQ);
   assign sdram_rd_req = (state == RD_REQ);
   assign busy         = (state != IDLE);
   assign rd_active    = (state == RD_REQ) || (state == RD_XFER);

   assign wr_elig = wr_en && (wr_fifo_lvl >= {1'b0, BURST_LEN});
   assign rd_elig = rd_en && (rd_fifo_lvl < RD_THRESH);
   assign wr_sum  = wr_addr + BURST_A;
   assign rd_sum  = rd_addr + BURST_A;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_wr  = 1'b0;
      grant_rd  = 1'b0;
      ack_first = 1'b0;
      ack_next  = 1'b0;
      wr_last   = 1'b0;
      rd_last   = 1'b0;
      case (state)
         IDLE: begin
            if (sdram_init_done) begin
               // Contention: write wins the very first grant, then alternate.
               if (wr_elig && rd_elig) begin
                  grant_wr = !any_grant || last_grant;
                  grant_rd = any_grant && !last_grant;
               end else begin
                  grant_wr = wr_elig;
                  grant_rd = rd_elig;
               end
            end
            if (grant_wr)      state_nxt = WR_REQ;
            else if (grant_rd) state_nxt = RD_REQ;
         end
         WR_REQ: begin
            if (sdram_wr_ack) begin
               ack_first = 1'b1;
               if (BURST_LEN == 9'd1) begin
                  wr_last   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = WR_XFER;
               end
            end
         end
         WR_XFER: begin
            if (sdram_wr_ack) begin
               ack_next = 1'b1;
               if (ack_cnt == BURST_LEN - 9'd1) begin
                  wr_last   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         RD_REQ: begin
            if (sdram_rd_ack) begin
               ack_first = 1'b1;
               if (BURST_LEN == 9'd1) begin
                  rd_last   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = RD_XFER;
               end
            end
         end
         RD_XFER: begin
            if (sdram_rd_ack) begin
               ack_next = 1'b1;
               if (ack_cnt == BURST_LEN - 9'd1) begin
                  rd_last   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sys_addr      <= BASE_ADDR;
         wr_addr       <= BASE_ADDR;
         rd_addr       <= BASE_ADDR;
         ack_cnt       <= 9'd0;
         any_grant     <= 1'b0;
         last_grant    <= 1'b0;
         rd_pend       <= 1'b0;
         wr_frame_done <= 1'b0;
         rd_frame_done <= 1'b0;
      end else begin
         wr_frame_done <= 1'b0;
         rd_frame_done <= 1'b0;

         if (grant_wr) begin
            sys_addr   <= wr_addr;
            last_grant <= 1'b0;
            any_grant  <= 1'b1;
         end else if (grant_rd) begin
            sys_addr   <= frame_sync ? BASE_ADDR : rd_addr;
            last_grant <= 1'b1;
            any_grant  <= 1'b1;
         end

         if (ack_first)     ack_cnt <= 9'd1;
         else if (ack_next) ack_cnt <= ack_cnt + 9'd1;

         if (wr_last) begin
            if (wr_sum == FRAME_END) begin
               wr_addr       <= BASE_ADDR;
               wr_frame_done <= 1'b1;
            end else begin
               wr_addr <= wr_sum;
            end
         end

         // A frame_sync seen during a read burst is held and replaces the increment.
         if (rd_last) begin
            rd_pend <= 1'b0;
            if (rd_sum == FRAME_END) begin
               rd_addr       <= BASE_ADDR;
               rd_frame_done <= 1'b1;
            end else if (rd_pend || frame_sync) begin
               rd_addr <= BASE_ADDR;
            end else begin
               rd_addr <= rd_sum;
            end
         end else if (frame_sync) begin
            if (rd_active) rd_pend <= 1'b1;
            else           rd_addr <= BASE_ADDR;
         end
      end
   end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: a small controller responder plus a frame-address model
// derived from the arbitration and wrap rules.
module tb_sdram_port_arb;

   localparam int BL = 256;
   localparam int FW = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sdram_init_done = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [9:0]  wr_fifo_lvl = '0;
   logic [9:0]  rd_fifo_lvl = '0;
   logic        frame_sync = 1'b0;
   logic        sdram_wr_req, sdram_rd_req;
   logic        sdram_wr_ack = 1'b0;
   logic        sdram_rd_ack = 1'b0;
   logic [9:0]  sdwr_byte, sdrd_byte;
   logic [21:0] sys_addr;
   logic        wr_frame_done, rd_frame_done, busy, last_grant;

   int checks = 0;
   int failures = 0;

   // reference model state
   int m_wr, m_rd;
   int m_last;
   bit m_any;

   sdram_port_arb #(
      .BURST_LEN(9'd256), .ADDR_W(22), .BASE_ADDR(22'd0),
      .FRAME_WORDS(22'd1024), .RD_THRESH(10'd512)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
      .wr_en(wr_en), .rd_en(rd_en), .wr_fifo_lvl(wr_fifo_lvl), .rd_fifo_lvl(rd_fifo_lvl),
      .frame_sync(frame_sync), .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
      .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
      .sdwr_byte(sdwr_byte), .sdrd_byte(sdrd_byte), .sys_addr(sys_addr),
      .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done),
      .busy(busy), .last_grant(last_grant)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      sdram_init_done = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      wr_fifo_lvl = '0; rd_fifo_lvl = '0; frame_sync = 1'b0;
      sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      m_wr = 0; m_rd = 0; m_last = 0; m_any = 1'b0;
   endtask

   // 0 = write, 1 = read, -1 = nothing eligible
   function automatic int exp_grant(bit we, bit re);
      if (we && re) return (!m_any || m_last == 1) ? 0 : 1;
      if (we) return 0;
      if (re) return 1;
      return -1;
   endfunction

   function automatic bit exp_pulse(int which);
      return (which == 0) ? (m_wr + BL == FW) : (m_rd + BL == FW);
   endfunction

   task automatic model_burst(int which, bit fs);
      if (which == 0) begin
         m_wr = (m_wr + BL) % FW;
         if (fs) m_rd = 0;
      end else begin
         m_rd = fs ? 0 : (m_rd + BL) % FW;
      end
      m_last = which;
      m_any  = 1'b1;
   endtask

   // which: 0 write, 1 read, 2 both, -1 timeout
   task automatic wait_req(input int budget, output int which, output int cycles);
      which = -1;
      cycles = 0;
      while (cycles < budget) begin
         if (sdram_wr_req === 1'b1 && sdram_rd_req === 1'b1) begin which = 2; break; end
         if (sdram_wr_req === 1'b1) begin which = 0; break; end
         if (sdram_rd_req === 1'b1) begin which = 1; break; end
         step();
         cycles++;
      end
   endtask

   // Controller responder: optional stall (refresh), then n_acks acks with random
   // gaps that may carry a stray ack of the other type.
   task automatic serve(input int which, input int n_acks, input int stall, input int fs_at,
                        output bit proto_ok, output bit done_pulse);
      logic [21:0] a0;
      int gap;
      proto_ok = 1'b1;
      done_pulse = 1'b0;
      a0 = sys_addr;
      for (int s = 0; s < stall; s++) begin
         step();
         if (((which == 0) ? sdram_wr_req : sdram_rd_req) !== 1'b1 || busy !== 1'b1 ||
             sys_addr !== a0) proto_ok = 1'b0;
      end
      for (int k = 1; k <= n_acks; k++) begin
         if (which == 0) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
         frame_sync = (k == fs_at);
         step();
         sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; frame_sync = 1'b0;
         if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) proto_ok = 1'b0;
         if (k < BL) begin
            if (busy !== 1'b1 || sys_addr !== a0) proto_ok = 1'b0;
            if (wr_frame_done !== 1'b0 || rd_frame_done !== 1'b0) proto_ok = 1'b0;
            if (k < n_acks) begin
               gap = $urandom_range(0, 2);
               for (int g = 0; g < gap; g++) begin
                  if ($urandom_range(0, 3) == 0) begin
                     if (which == 0) sdram_rd_ack = 1'b1; else sdram_wr_ack = 1'b1;
                  end
                  step();
                  sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
                  if (busy !== 1'b1 || sys_addr !== a0 || sdram_wr_req !== 1'b0 ||
                      sdram_rd_req !== 1'b0) proto_ok = 1'b0;
               end
            end
         end else begin
            if (busy !== 1'b0) proto_ok = 1'b0;
            done_pulse = (which == 0) ? wr_frame_done : rd_frame_done;
            if (((which == 0) ? rd_frame_done : wr_frame_done) !== 1'b0) proto_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset_dut();
      checks++; if (sdram_wr_req !== 1'b0) begin failures++; $display("FAIL rst_wr_req: got %b want 0", sdram_wr_req); end
      checks++; if (sdram_rd_req !== 1'b0) begin failures++; $display("FAIL rst_rd_req: got %b want 0", sdram_rd_req); end
      checks++; if (sdwr_byte !== 10'd256) begin failures++; $display("FAIL rst_sdwr_byte: got %0d want 256", sdwr_byte); end
      checks++; if (sdrd_byte !== 10'd256) begin failures++; $display("FAIL rst_sdrd_byte: got %0d want 256", sdrd_byte); end
      checks++; if (sys_addr !== 22'd0) begin failures++; $display("FAIL rst_sys_addr: got %0h want 0", sys_addr); end
      checks++; if (wr_frame_done !== 1'b0 || rd_frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done: got %b%b want 00", wr_frame_done, rd_frame_done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (last_grant !== 1'b0) begin failures++; $display("FAIL rst_last_grant: got %b want 0", last_grant); end
   endtask

   task automatic test_write_only();
      int which, cyc;
      bit ok, pulse, ep;
      reset_dut();
      sdram_init_done = 1'b1; wr_en = 1'b1; wr_fifo_lvl = 10'd300; rd_en = 1'b0;
      for (int b = 0; b < 5; b++) begin
         wait_req(600, which, cyc);
         checks++; if (which !== 0) begin failures++; $display("FAIL wo_grant[%0d]: got %0d want 0", b, which); end
         if (b > 0 && b != 4) begin
            checks++; if (cyc !== 1) begin failures++; $display("FAIL wo_idle_gap[%0d]: got %0d want 1", b, cyc); end
         end
         checks++; if (sys_addr !== 22'(m_wr)) begin failures++; $display("FAIL wo_addr[%0d]: got %0d want %0d", b, sys_addr, m_wr); end
         ep = exp_pulse(0);
         serve(0, BL, 0, 0, ok, pulse);
         checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wo_proto[%0d]: got %b want 1", b, ok); end
         checks++; if (pulse !== ep) begin failures++; $display("FAIL wo_frame_done[%0d]: got %b want %b", b, pulse, ep); end
         model_burst(0, 1'b0);
         if (b == 3) begin
            step();
            checks++; if (wr_frame_done !== 1'b0 || sdram_wr_req !== 1'b1) begin failures++; $display("FAIL wo_pulse_width: got done=%b req=%b want 0,1", wr_frame_done, sdram_wr_req); end
         end
      end
   endtask

   task automatic test_alternate();
      int which, cyc, eg;
      bit ok, pulse, ep;
      reset_dut();
      sdram_init_done = 1'b1; wr_en = 1'b1; wr_fifo_lvl = 10'd400; rd_en = 1'b1; rd_fifo_lvl = 10'd0;
      for (int b = 0; b < 6; b++) begin
         eg = exp_grant(1'b1, 1'b1);
         wait_req(600, which, cyc);
         checks++; if (which !== eg) begin failures++; $display("FAIL alt_grant[%0d]: got %0d want %0d", b, which, eg); end
         checks++; if (sys_addr !== 22'((eg == 0) ? m_wr : m_rd)) begin failures++; $display("FAIL alt_addr[%0d]: got %0d want %0d", b, sys_addr, (eg == 0) ? m_wr : m_rd); end
         ep = exp_pulse(eg);
         serve(eg, BL, 0, 0, ok, pulse);
         checks++; if (ok !== 1'b1 || pulse !== ep) begin failures++; $display("FAIL alt_burst[%0d]: got ok=%b pulse=%b want 1,%b", b, ok, pulse, ep); end
         checks++; if (last_grant !== 1'(eg)) begin failures++; $display("FAIL alt_last_grant[%0d]: got %b want %0d", b, last_grant, eg); end
         model_burst(eg, 1'b0);
      end
   endtask

   task automatic test_frame_sync();
      // -1: frame_sync while idle before the burst; >0: frame_sync at that ack
      int fs_tab[11] = '{0, 0, -1, 0, 0, 100, 0, 0, 0, 200, 0};
      int which, cyc, fs;
      bit ok, pulse, ep;
      reset_dut();
      sdram_init_done = 1'b1; rd_en = 1'b1; rd_fifo_lvl = 10'd0; wr_en = 1'b0;
      for (int b = 0; b < 11; b++) begin
         fs = fs_tab[b];
         if (fs < 0) begin
            rd_en = 1'b0;
            step();
            frame_sync = 1'b1;
            step();
            frame_sync = 1'b0;
            m_rd = 0;
            rd_en = 1'b1;
         end
         wait_req(600, which, cyc);
         checks++; if (which !== 1) begin failures++; $display("FAIL fs_grant[%0d]: got %0d want 1", b, which); end
         checks++; if (sys_addr !== 22'(m_rd)) begin failures++; $display("FAIL fs_addr[%0d]: got %0d want %0d", b, sys_addr, m_rd); end
         ep = exp_pulse(1);
         serve(1, BL, 0, (fs > 0) ? fs : 0, ok, pulse);
         checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fs_proto[%0d]: got %b want 1", b, ok); end
         checks++; if (pulse !== ep) begin failures++; $display("FAIL fs_frame_done[%0d]: got %b want %b", b, pulse, ep); end
         model_burst(1, fs > 0);
      end
   endtask

   task automatic test_init_done();
      int which, cyc;
      bit ok, pulse, bad;
      reset_dut();
      sdram_init_done = 1'b0; wr_en = 1'b1; wr_fifo_lvl = 10'd400; rd_en = 1'b1; rd_fifo_lvl = 10'd0;
      bad = 1'b0;
      repeat (1000) begin
         step();
         if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL init_no_req: got activity=%b want 0", bad); end
      sdram_init_done = 1'b1;
      wait_req(10, which, cyc);
      checks++; if (which !== 0 || cyc !== 1) begin failures++; $display("FAIL init_first_req: got grant=%0d cycles=%0d want 0,1", which, cyc); end
      serve(0, BL, 0, 0, ok, pulse);
      checks++; if (ok !== 1'b1 || pulse !== 1'b0) begin failures++; $display("FAIL init_burst: got ok=%b pulse=%b want 1,0", ok, pulse); end
      model_burst(0, 1'b0);
   endtask

   task automatic test_refresh_stray();
      int which, cyc;
      bit ok, pulse, bad;
      reset_dut();
      sdram_init_done = 1'b1; wr_fifo_lvl = 10'd300; rd_fifo_lvl = 10'd0;
      bad = 1'b0;
      repeat (5) begin
         sdram_rd_ack = 1'b1; sdram_wr_ack = 1'b1;
         step();
         sdram_rd_ack = 1'b0; sdram_wr_ack = 1'b0;
         if (busy !== 1'b0 || sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL stray_idle: got activity=%b want 0", bad); end
      wr_en = 1'b1;
      wait_req(10, which, cyc);
      checks++; if (which !== 0 || sys_addr !== 22'd0) begin failures++; $display("FAIL refresh_wr_start: got grant=%0d addr=%0d want 0,0", which, sys_addr); end
      serve(0, BL, 50, 0, ok, pulse);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL refresh_wr_burst: got %b want 1", ok); end
      model_burst(0, 1'b0);
      wr_en = 1'b0; rd_en = 1'b1;
      wait_req(10, which, cyc);
      checks++; if (which !== 1 || sys_addr !== 22'd0) begin failures++; $display("FAIL refresh_rd_start: got grant=%0d addr=%0d want 1,0", which, sys_addr); end
      serve(1, BL, 50, 0, ok, pulse);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL refresh_rd_burst: got %b want 1", ok); end
      model_burst(1, 1'b0);
      wr_en = 1'b1; rd_en = 1'b0;
      wait_req(10, which, cyc);
      checks++; if (which !== 0 || sys_addr !== 22'(m_wr)) begin failures++; $display("FAIL refresh_next_addr: got grant=%0d addr=%0d want 0,%0d", which, sys_addr, m_wr); end
      serve(0, BL, 0, 0, ok, pulse);
      model_burst(0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int which, cyc;
      bit ok, pulse;
      reset_dut();
      sdram_init_done = 1'b1; wr_en = 1'b1; wr_fifo_lvl = 10'd300;
      wait_req(10, which, cyc);
      serve(0, BL, 0, 0, ok, pulse);
      model_burst(0, 1'b0);
      wait_req(10, which, cyc);
      checks++; if (which !== 0 || sys_addr !== 22'd256) begin failures++; $display("FAIL rmid_start: got grant=%0d addr=%0d want 0,256", which, sys_addr); end
      serve(0, 128, 0, 0, ok, pulse);
      checks++; if (ok !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rmid_partial: got ok=%b busy=%b want 1,1", ok, busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) begin failures++; $display("FAIL rmid_async_clear: got busy=%b req=%b%b want 0,00", busy, sdram_wr_req, sdram_rd_req); end
      checks++; if (sys_addr !== 22'd0 || last_grant !== 1'b0 || wr_frame_done !== 1'b0) begin failures++; $display("FAIL rmid_async_regs: got addr=%0d lg=%b done=%b want 0,0,0", sys_addr, last_grant, wr_frame_done); end
      reset_dut();
      sdram_init_done = 1'b1; wr_en = 1'b1; wr_fifo_lvl = 10'd300;
      wait_req(10, which, cyc);
      checks++; if (which !== 0 || sys_addr !== 22'd0) begin failures++; $display("FAIL rmid_restart: got grant=%0d addr=%0d want 0,0", which, sys_addr); end
      serve(0, BL, 0, 0, ok, pulse);
      model_burst(0, 1'b0);
   endtask

   task automatic test_thresholds();
      int which, cyc;
      bit ok, pulse;
      reset_dut();
      sdram_init_done = 1'b1;
      wr_en = 1'b1; wr_fifo_lvl = 10'd255; rd_en = 1'b1; rd_fifo_lvl = 10'd512;
      repeat (3) step();
      checks++; if (busy !== 1'b0 || sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) begin failures++; $display("FAIL thr_none: got busy=%b want 0", busy); end
      rd_fifo_lvl = 10'd511;
      wait_req(10, which, cyc);
      checks++; if (which !== 1) begin failures++; $display("FAIL thr_rd_511: got %0d want 1", which); end
      serve(1, BL, 0, 0, ok, pulse);
      model_burst(1, 1'b0);
      rd_en = 1'b0; wr_fifo_lvl = 10'd256;
      wait_req(10, which, cyc);
      checks++; if (which !== 0 || sys_addr !== 22'd0) begin failures++; $display("FAIL thr_wr_256: got grant=%0d addr=%0d want 0,0", which, sys_addr); end
      serve(0, BL, 0, 0, ok, pulse);
      model_burst(0, 1'b0);
   endtask

   task automatic test_random();
      int which, cyc, eg, fs, st;
      bit ok, pulse, ep, we, re;
      reset_dut();
      sdram_init_done = 1'b1;
      for (int b = 0; b < 18; b++) begin
         do begin
            wr_en = 1'($urandom_range(0, 3) != 0);
            rd_en = 1'($urandom_range(0, 3) != 0);
            wr_fifo_lvl = 10'($urandom_range(240, 400));
            rd_fifo_lvl = 10'($urandom_range(480, 530));
            we = wr_en && (wr_fifo_lvl >= 10'd256);
            re = rd_en && (rd_fifo_lvl < 10'd512);
         end while (!we && !re);
         eg = exp_grant(we, re);
         wait_req(10, which, cyc);
         checks++; if (which !== eg) begin failures++; $display("FAIL rnd_grant[%0d]: got %0d want %0d", b, which, eg); end
         checks++; if (sys_addr !== 22'((eg == 0) ? m_wr : m_rd)) begin failures++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", b, sys_addr, (eg == 0) ? m_wr : m_rd); end
         fs = ($urandom_range(0, 2) == 0) ? $urandom_range(1, BL) : 0;
         st = $urandom_range(0, 5);
         ep = exp_pulse(eg);
         serve(eg, BL, st, fs, ok, pulse);
         checks++; if (ok !== 1'b1 || pulse !== ep) begin failures++; $display("FAIL rnd_burst[%0d]: got ok=%b pulse=%b want 1,%b", b, ok, pulse, ep); end
         model_burst(eg, fs > 0);
      end
   endtask

   initial begin
      test_reset();
      test_write_only();
      test_alternate();
      test_frame_sync();
      test_init_done();
      test_refresh_stray();
      test_reset_mid();
      test_thresholds();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
